// File: rtl/servant_uart_pkg.sv
// Shared types and helpers for the servant UART receiver.
// The optional output FIFO is selected with SERVANT_UART_RX_FIFO_EN.
package servant_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/servant_uart_rx_fifo.sv
// Synchronous byte FIFO; a pop in the same cycle lets a push into a full FIFO.
// Only instantiated when SERVANT_UART_RX_FIFO_EN is defined.
module servant_uart_rx_fifo
    import servant_uart_pkg::*;
#(
    parameter int aw = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 full,
    output logic                 empty
);

    logic [DATA_BITS-1:0] mem [2**aw];
    logic [aw-1:0]        wr_ptr;
    logic [aw-1:0]        rd_ptr;
    logic [aw:0]          count;
    logic                 do_push;
    logic                 do_pop;

    // count never exceeds depth, so its MSB alone marks full
    assign full    = count[aw];
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output and error pulses.
// Define SERVANT_UART_RX_FIFO_EN for a 2**fifo_aw FIFO, else a single holding register.
module servant_uart_rx
    import servant_uart_pkg::*;
#(
    parameter int clk_freq_hz = 32000000,
    parameter int baud_rate   = 172800,
    parameter int fifo_aw     = 3
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rdt,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int          DIV     = calc_div(clk_freq_hz, baud_rate);
    localparam int          HALF    = DIV / 2;
    localparam logic [15:0] DIV_LD  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LD = 16'(HALF - 1);

    generate
        if (DIV < 4 || fifo_aw < 1) begin : g_param_check
            $error("servant_uart_rx: DIV must be >= 4 and fifo_aw >= 1");
        end
    endgenerate

    logic                 rx_p0;
    logic                 rx_p1;
    state_t               state;
    logic [15:0]          cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 push_p0;

    // Stage 0: two-flop synchronizer, reset to the idle line level
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= i_rx;
            rx_p1 <= rx_p0;
        end
    end

    // Stage 1: frame FSM; push_p0 and o_frame_err are registered at the stop sample
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            push_p0     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            push_p0     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_p1) begin
                        state <= START;
                        cnt   <= HALF_LD;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_p1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        state   <= DATA;
                        cnt     <= DIV_LD;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_p1, shreg[DATA_BITS-1:1]};
                        cnt     <= DIV_LD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_p1) begin
                        push_p0 <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else begin
                        o_frame_err <= 1'b1;
                        state       <= BRK;
                        cnt         <= '0;
                    end
                end
                BRK: begin
                    // a held-low line must go high before another frame can start
                    if (rx_p1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy = (state != IDLE);

    // Stage 2: output buffering
`ifdef SERVANT_UART_RX_FIFO_EN
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic [DATA_BITS-1:0] last_rdt;

    assign pop   = o_vld & i_rdy;
    assign o_vld = ~fifo_empty;
    assign o_rdt = fifo_empty ? last_rdt : fifo_rdata;

    servant_uart_rx_fifo #(
        .aw (fifo_aw)
    ) u_fifo (
        .clk   (wb_clk),
        .rst_n (wb_rst_n),
        .push  (push_p0),
        .pop   (pop),
        .wdata (shreg),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            last_rdt  <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= push_p0 & fifo_full & ~pop;
            if (pop) begin
                last_rdt <= fifo_rdata;
            end
        end
    end
`else
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            o_rdt     <= '0;
            o_vld     <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (push_p0) begin
                if (o_vld && !i_rdy) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_rdt <= shreg;
                    o_vld <= 1'b1;
                end
            end else if (o_vld && i_rdy) begin
                o_vld <= 1'b0;
            end
        end
    end
`endif

endmodule
